// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer and the processing element it feeds.
package mac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CLEAR  = 3'd1,
        ST_STREAM = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_OUT    = 3'd4
    } mac_seq_state_e;

    function automatic int acc_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: joins the A/B operand streams into registered PE pairs,
// clears the PE accumulator per command and hands the final sum out on a ready/valid port.
//
// state  | meaning
// IDLE   | waiting for start_i
// CLEAR  | one-cycle PE accumulator clear
// STREAM | joining A/B beats until the count reaches zero
// DRAIN  | two cycles for the last pair to land in the PE accumulator
// OUT    | result held until res_ready_i
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int LEN_WIDTH  = 16,
    localparam int ACC_W      = acc_width(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    input  logic [DATA_WIDTH-1:0] a_data_i,
    input  logic                  a_valid_i,
    output logic                  a_ready_o,
    input  logic [DATA_WIDTH-1:0] b_data_i,
    input  logic                  b_valid_i,
    output logic                  b_ready_o,
    output logic [DATA_WIDTH-1:0] pe_a_o,
    output logic [DATA_WIDTH-1:0] pe_b_o,
    output logic                  pe_a_valid_o,
    output logic                  pe_b_valid_o,
    output logic                  pe_acc_clr_o,
    input  logic [ACC_W-1:0]      pe_acc_i,
    output logic [ACC_W-1:0]      res_data_o,
    output logic                  res_valid_o,
    input  logic                  res_ready_i
);

    mac_seq_state_e          state_q, state_d;
    logic [LEN_WIDTH-1:0]    cnt_q, cnt_d;
    logic                    drain_q, drain_d;
    logic [DATA_WIDTH-1:0]   pe_a_q, pe_a_d;
    logic [DATA_WIDTH-1:0]   pe_b_q, pe_b_d;
    logic                    pe_vld_q, pe_vld_d;
    logic [ACC_W-1:0]        res_data_q, res_data_d;
    logic                    res_valid_q, res_valid_d;
    logic                    in_stream;
    logic                    fire;

    assign in_stream = (state_q == ST_STREAM);
    assign fire      = in_stream & a_valid_i & b_valid_i;

    // Each ready depends only on the other stream's valid, so a lone beat is never taken.
    assign a_ready_o = in_stream & b_valid_i;
    assign b_ready_o = in_stream & a_valid_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        pe_a_d      = '0;
        pe_b_d      = '0;
        pe_vld_d    = 1'b0;
        res_data_d  = res_data_q;
        res_valid_d = res_valid_q;

        if (fire) begin
            pe_a_d   = a_data_i;
            pe_b_d   = b_data_i;
            pe_vld_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    cnt_d   = len_i;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                drain_d = 1'b0;
                state_d = (cnt_q != '0) ? ST_STREAM : ST_DRAIN;
            end
            ST_STREAM: begin
                if (fire) begin
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        drain_d = 1'b0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    drain_d     = 1'b0;
                    res_data_d  = pe_acc_i;
                    res_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end
            end
            ST_OUT: begin
                if (res_ready_i) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            drain_q     <= 1'b0;
            pe_a_q      <= '0;
            pe_b_q      <= '0;
            pe_vld_q    <= 1'b0;
            res_data_q  <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            pe_a_q      <= pe_a_d;
            pe_b_q      <= pe_b_d;
            pe_vld_q    <= pe_vld_d;
            res_data_q  <= res_data_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign pe_acc_clr_o = (state_q == ST_CLEAR);
    assign pe_a_o       = pe_a_q;
    assign pe_b_o       = pe_b_q;
    assign pe_a_valid_o = pe_vld_q;
    assign pe_b_valid_o = pe_vld_q;
    assign res_data_o   = res_data_q;
    assign res_valid_o  = res_valid_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl with a behavioural PE model and a result scoreboard.
module tb_mac_seq_ctrl;

    localparam int DW = 16;
    localparam int LW = 16;
    localparam int AW = 2 * DW;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          start_i;
    logic [LW-1:0] len_i;
    logic          busy_o;
    logic [DW-1:0] a_data_i, b_data_i;
    logic          a_valid_i, b_valid_i;
    logic          a_ready_o, b_ready_o;
    logic [DW-1:0] pe_a_o, pe_b_o;
    logic          pe_a_valid_o, pe_b_valid_o, pe_acc_clr_o;
    logic [AW-1:0] pe_acc;
    logic [AW-1:0] res_data_o;
    logic          res_valid_o;
    logic          res_ready_i;

    mac_seq_ctrl #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .len_i        (len_i),
        .busy_o       (busy_o),
        .a_data_i     (a_data_i),
        .a_valid_i    (a_valid_i),
        .a_ready_o    (a_ready_o),
        .b_data_i     (b_data_i),
        .b_valid_i    (b_valid_i),
        .b_ready_o    (b_ready_o),
        .pe_a_o       (pe_a_o),
        .pe_b_o       (pe_b_o),
        .pe_a_valid_o (pe_a_valid_o),
        .pe_b_valid_o (pe_b_valid_o),
        .pe_acc_clr_o (pe_acc_clr_o),
        .pe_acc_i     (pe_acc),
        .res_data_o   (res_data_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i)
    );

    always #5 clk_i = ~clk_i;

    // PE model: no reset of its own, so only the sequencer's clear can zero it.
    logic [AW-1:0] pe_acc_r = 32'h1234_5678;
    assign pe_acc = pe_acc_r;
    always @(posedge clk_i) begin
        if (pe_acc_clr_o)
            pe_acc_r <= '0;
        else if (pe_a_valid_o || pe_b_valid_o)
            pe_acc_r <= pe_acc_r + (AW'(pe_a_o) * AW'(pe_b_o));
    end

    int cyc = 0;
    always @(posedge clk_i) cyc++;

    int n_checks = 0;
    int n_pass   = 0;
    logic [AW-1:0] sb_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk_i) begin
        if (rst_ni && res_valid_o && res_ready_i) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got result %0h expected none", res_data_o);
            end else begin
                logic [AW-1:0] e;
                e = sb_q.pop_front();
                if (res_data_o === e) n_pass++;
                else $display("FAIL sb_result: got %0h expected %0h", res_data_o, e);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    typedef struct {
        int              n;
        logic [3:0][DW-1:0] a;
        logic [3:0][DW-1:0] b;
        int              a_per;
        int              b_per;
        int              hold;
        logic [AW-1:0]   exp;
    } vec_t;

    vec_t vecs[6];

    task automatic run_vec(input vec_t v);
        int s, ka, c, w, last;
        sb_q.push_back(v.exp);
        s       = cyc;
        start_i = 1'b1;
        len_i   = LW'(v.n);
        step();
        start_i = 1'b0;
        check("clr_in_clear", pe_acc_clr_o, 1);
        check("busy_in_clear", busy_o, 1);
        ka = 0; c = 0; last = -1;
        while (ka < v.n && c < 200) begin
            a_valid_i = (c % v.a_per) == 0;
            b_valid_i = (c % v.b_per) == 0;
            a_data_i  = v.a[ka];
            b_data_i  = v.b[ka];
            #2;
            check("join", (a_valid_i && a_ready_o), (b_valid_i && b_ready_o));
            if (a_valid_i && a_ready_o && b_valid_i && b_ready_o) begin
                ka++;
                last = cyc;
            end
            step();
            c++;
        end
        check("fire_count", ka, v.n);
        w = 0;
        while (!res_valid_o && w < 10) begin
            a_valid_i = 1'b1; b_valid_i = 1'b1;
            a_data_i  = 16'hDEAD; b_data_i = 16'hBEEF;
            #2;
            check("no_ready_post_stream", {a_ready_o, b_ready_o}, 2'b00);
            step();
            w++;
        end
        check("res_valid", res_valid_o, 1);
        if (v.n == 0) check("latency_n0", cyc, s + 4);
        else          check("latency", cyc, last + 3);
        for (int h = 0; h < v.hold; h++) begin
            start_i = 1'b1; a_valid_i = 1'b1; b_valid_i = 1'b1;
            #2;
            check("hold_data", res_data_o, v.exp);
            check("hold_valid", res_valid_o, 1);
            check("hold_no_ready", {a_ready_o, b_ready_o}, 2'b00);
            step();
        end
        start_i     = 1'b1;
        res_ready_i = 1'b1;
        step();
        start_i = 1'b0; res_ready_i = 1'b0;
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        check("busy_after_hs", busy_o, 0);
        check("valid_after_hs", res_valid_o, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pe_a"}, pe_a_o, 0);
        check({tag, "_pe_b"}, pe_b_o, 0);
        check({tag, "_pe_vld"}, {pe_a_valid_o, pe_b_valid_o}, 2'b00);
        check({tag, "_res"}, {res_valid_o, res_data_o}, 0);
        check({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        vecs[0] = '{n:3, a:{16'd0, 16'd1, 16'd4, 16'd2}, b:{16'd0, 16'd7, 16'd5, 16'd3},
                    a_per:1, b_per:1, hold:0, exp:32'd33};
        vecs[1] = '{n:2, a:{16'd0, 16'd0, 16'd3, 16'd10}, b:{16'd0, 16'd0, 16'd3, 16'd10},
                    a_per:1, b_per:3, hold:0, exp:32'd109};
        vecs[2] = '{n:0, a:'0, b:'0, a_per:1, b_per:1, hold:0, exp:32'd0};
        vecs[3] = '{n:2, a:{16'd0, 16'd0, 16'hFFFF, 16'hFFFF}, b:{16'd0, 16'd0, 16'hFFFF, 16'hFFFF},
                    a_per:1, b_per:1, hold:0, exp:32'hFFFC_0002};
        vecs[4] = '{n:4, a:{16'd4, 16'd3, 16'd2, 16'd1}, b:{16'd8, 16'd7, 16'd6, 16'd5},
                    a_per:2, b_per:1, hold:0, exp:32'd70};
        vecs[5] = '{n:1, a:{16'd0, 16'd0, 16'd0, 16'd9}, b:{16'd0, 16'd0, 16'd0, 16'd9},
                    a_per:1, b_per:1, hold:5, exp:32'd81};

        rst_ni = 1'b0; start_i = 1'b0; len_i = '0;
        a_data_i = '0; b_data_i = '0; a_valid_i = 1'b0; b_valid_i = 1'b0;
        res_ready_i = 1'b0;
        repeat (3) step();
        check_reset_outputs("reset");
        a_valid_i = 1'b1; b_valid_i = 1'b1;
        #1;
        check("idle_no_ready", {a_ready_o, b_ready_o}, 2'b00);
        a_valid_i = 1'b0; b_valid_i = 1'b0;
        rst_ni = 1'b1;
        step();

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Abandon a command mid-stream while the PE holds a partial sum.
        start_i = 1'b1; len_i = 16'd4;
        step();
        start_i = 1'b0;
        a_valid_i = 1'b1; b_valid_i = 1'b1; a_data_i = 16'd5; b_data_i = 16'd5;
        step();
        step();
        b_valid_i = 1'b0;
        repeat (3) step();
        check("partial_acc_nonzero", (pe_acc != 0), 1);
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midrst");
        a_valid_i = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        vecs[0] = '{n:1, a:{16'd0, 16'd0, 16'd0, 16'd6}, b:{16'd0, 16'd0, 16'd0, 16'd7},
                    a_per:1, b_per:1, hold:0, exp:32'd42};
        run_vec(vecs[0]);

        repeat (2) step();
        check("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer placed directly upstream of the MAC processing element (mac_pe).
- Accepts a dot-product command of length N and joins two ready/valid operand streams (A, B) into registered operand pairs driven into the PE.
- Clears the PE accumulator before each command, waits for the final product to settle, then captures the PE accumulator into a ready/valid result port.
- A wrapper instantiates one mac_seq_ctrl plus one mac_pe.

Parameters:
- DATA_WIDTH, 16, operand width; must match the PE.
- LEN_WIDTH, 16, width of the command length field.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  command strobe; sampled only in IDLE.
- len_i  in  LEN_WIDTH  number of operand pairs N; latched with start_i.
- busy_o  out  1  high whenever state != IDLE.
- a_data_i  in  DATA_WIDTH  A stream data.
- a_valid_i  in  1  A stream valid.
- a_ready_o  out  1  A stream ready.
- b_data_i  in  DATA_WIDTH  B stream data.
- b_valid_i  in  1  B stream valid.
- b_ready_o  out  1  B stream ready.
- pe_a_o  out  DATA_WIDTH  operand to PE a_i.
- pe_b_o  out  DATA_WIDTH  operand to PE b_i.
- pe_a_valid_o  out  1  to PE a_valid_i.
- pe_b_valid_o  out  1  to PE b_valid_i.
- pe_acc_clr_o  out  1  to PE acc_clr_i.
- pe_acc_i  in  2*DATA_WIDTH  from PE acc_o.
- res_data_o  out  2*DATA_WIDTH  captured dot-product result.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  result ready.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE; counter = 0.
  - pe_a_o, pe_b_o, pe_a_valid_o, pe_b_valid_o, res_data_o, res_valid_o = 0.
  - Reset mid-command abandons the command; no result is produced.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, OUT.
- IDLE:
  - On start_i, latch cnt = len_i and go to CLEAR.
  - start_i is ignored in every other state; there is no queueing.
- CLEAR (1 cycle):
  - pe_acc_clr_o = 1; pe_acc_clr_o is decoded from the state register only.
  - Next state is STREAM if cnt != 0, else DRAIN.
- STREAM:
  - a_ready_o = b_valid_i; b_ready_o = a_valid_i. Both ready outputs are 0 outside STREAM.
  - Fire = a_valid_i & b_valid_i.
  - On fire: register pe_a_o = a_data_i, pe_b_o = b_data_i, pe_a_valid_o = pe_b_valid_o = 1 for the next cycle; cnt decrements.
  - On no fire: both PE valids = 0 and both PE operands = 0 next cycle, so the PE accumulates nothing regardless of its OR-of-valids rule.
  - The fire that brings cnt to 0 moves the FSM to DRAIN.
- DRAIN (exactly 2 cycles, 1-bit sub-counter):
  - Cycle 1 presents the last pair to the PE.
  - In cycle 2, pe_acc_i is final.
  - At the edge ending cycle 2: res_data_o = pe_acc_i, res_valid_o = 1, go to OUT.
- OUT:
  - res_data_o is held stable while res_valid_o = 1 and res_ready_i = 0.
  - On res_valid_o & res_ready_i: res_valid_o = 0 and go to IDLE (busy_o low next cycle).
  - A start_i in the handshake cycle is ignored.
- Latency:
  - Last fire at cycle t gives res_valid_o at t+3.
  - A start_i accepted at t with N = 0 gives res_valid_o = 1, res_data_o = 0 at t+4.
- Streams:
  - Valid-to-ready combinational paths exist; upstream valids must not depend on ready.
  - A beat offered on one stream alone is never consumed.
- Arithmetic:
  - Accumulation width and unsigned wrap-around belong to the PE; this block performs no arithmetic beyond the counter.
  - N up to 2^LEN_WIDTH - 1 is supported.
- Simultaneous events: a_valid_i/b_valid_i outside STREAM produce no ready and no effect.

Decomposition:
- Shared package mac_pkg holds:
  - the state enum type mac_seq_state_e;
  - the function acc_width(DATA_WIDTH) = 2*DATA_WIDTH, used by this block and by mac_pe users.
- No internal sub-module: the join logic and counter are small and stay inline.
- Integration wrapper mac_unit (separate file) instantiates mac_seq_ctrl and mac_pe.

Test Plan:
- N=3, pairs (2,3), (4,5), (1,7) with both streams always valid -> three consecutive fires; res_data_o = 33 at last-fire+3; busy_o drops the cycle after res_ready_i handshake.
- N=2, A valid every cycle, B valid only every 3rd cycle -> A is not consumed until B is present; exactly 2 fires; pairs (10,10), (3,3) give res_data_o = 109.
- N=0 -> CLEAR for one cycle, no ready asserted, res_data_o = 0 with res_valid_o = 1 four cycles after the start_i cycle.
- Back-pressure: res_ready_i held low 5 cycles in OUT -> res_data_o stable, start_i pulses ignored, no ready asserted on either stream.
- Reset asserted mid-STREAM after 1 of 4 fires -> all outputs 0 immediately; a new N=1 command (6,7) gives 42, proving the accumulator is cleared via CLEAR.
- DATA_WIDTH=16, N=2 with pairs (0xFFFF,0xFFFF) x2 -> res_data_o = 0xFFFC0002 (32-bit wrap handled by PE).
